dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter N, default 32: address and data width.
REQ-002 SHALL have parameter DEPTH, default 64: number of valid memory words; word addresses 0..DEPTH-1.
REQ-003 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  in  2  per-requester request valid; bit i = requester i.
REQ-006 SHALL have port req_ready  out  2  per-requester request accepted, one-hot or zero.
REQ-007 SHALL have port req_we  in  2  per-requester write flag: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  in  2*N  word addresses; bits [N-1:0] = requester 0.
REQ-009 SHALL have port req_wdata  in  2*N  write data, same packing.
REQ-010 SHALL have port rsp_valid  out  2  response valid to requester i.
REQ-011 SHALL have port rsp_ready  in  2  requester i takes response.
REQ-012 SHALL have port rsp_rdata  out  N  read data, shared, meaningful only with a rsp_valid bit set.
REQ-013 SHALL have port rsp_err  out  1  response is out-of-range error.
REQ-014 SHALL have port mem_rw  out  1  memory control: 1 = read, 0 = write on next clk edge.
REQ-015 SHALL have port mem_addr  out  N  memory word address.
REQ-016 SHALL have port mem_wdata  out  N  memory write data.
REQ-017 SHALL have port mem_rdata  in  N  combinational memory read data, valid while mem_rw = 1.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RESP; one transaction outstanding max.
REQ-019 IDLE: if any req_valid bit is set, SHALL pick winner per REQ-025, assert req_ready for winner only (combinational, same cycle), capture we/addr/wdata/owner, go to ACCESS; else stay in IDLE.
REQ-020 ACCESS (exactly one cycle): SHALL drive mem_addr/mem_wdata from captured request; mem_rw = 0 only if captured write and addr < DEPTH, else 1; on read, SHALL register mem_rdata into rsp_rdata; go to RESP.
REQ-021 RESP: SHALL assert rsp_valid[owner] only; hold rsp_rdata/rsp_err stable; on rsp_ready[owner] = 1, go to IDLE; no new request is accepted in this cycle.
REQ-022 Minimum latency: request accepted at edge T, rsp_valid high in cycle T+2; peak throughput one transaction per 3 cycles.
REQ-023 Write response: rsp_rdata = 0, rsp_err = 0 when in range.
REQ-024 addr >= DEPTH: no memory write, rsp_rdata = 0, rsp_err = 1; transaction otherwise completes normally.
REQ-025 Arbitration: single requester valid -> it wins; both valid -> per Configuration.
REQ-026 Outside ACCESS, mem_rw SHALL be 1 and mem_addr/mem_wdata SHALL be 0 (no spurious writes).
REQ-027 req_ready SHALL be 0 in ACCESS and RESP; requests held by requesters, not buffered.
REQ-028 Address comparison SHALL use full N-bit unsigned addr; no wrap-around or truncation.

Reset
REQ-029 While rst_n = 0: state IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mem_rw = 1, mem_addr = 0, mem_wdata = 0, last-grant register = 1.
REQ-030 Reset asserted in ACCESS or RESP SHALL drop the transaction: no memory write, no response issued after reset release.

Configuration
REQ-031 Macro DMEM_ARB_RR_EN defined: round-robin, contention granted to requester not granted last; last-grant updated on every acceptance.
REQ-032 Macro DMEM_ARB_RR_EN undefined: fixed priority, requester 0 always wins contention; last-grant register SHALL not exist.

Verification
REQ-033 Reset, then req_valid = 01 write addr 5 data 0xDEADBEEF -> req_ready = 01 same cycle, mem_rw = 0 in T+1 only, rsp_valid = 01 in T+2 with rsp_err = 0.
REQ-034 Then requester 1 read addr 5 -> rsp_valid = 10 at T+2, rsp_rdata = 0xDEADBEEF.
REQ-035 Both valid continuously, DMEM_ARB_RR_EN defined -> grants 0,1,0,1; undefined -> grants 0,0,0,0.
REQ-036 Write addr 64 data 0x1 -> mem_rw stays 1 throughout, rsp_err = 1, rsp_rdata = 0; subsequent read addr 0 returns 0.
REQ-037 rsp_ready held 0 for 4 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready = 00 while other requester waits; released next cycle after rsp_ready = 1.
REQ-038 rst_n low during ACCESS of write addr 3 data 0x55 -> mem_rw = 1 that cycle, no rsp_valid after release, read addr 3 returns 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter in front of a single-port data memory. It accepts one
// transaction at a time (IDLE -> ACCESS -> RESP), performs a single-cycle
// memory access and returns a response to the requester that owns it.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin on contention (last-grant register)
//                   undefined -> fixed priority, requester 0 wins contention
//
// Parameters:
//   N      address/data width
//   DEPTH  number of valid memory words (word addresses 0..DEPTH-1)
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   req_valid[2]  request valid per requester
//   req_ready[2]  request accepted (combinational, IDLE only)
//   req_we[2]     write flag per requester
//   req_addr      {addr1, addr0}, N bits each
//   req_wdata     {wdata1, wdata0}, N bits each
//   rsp_valid[2]  response valid to the owning requester
//   rsp_ready[2]  requester takes the response
//   rsp_rdata     read data (shared)
//   rsp_err       out-of-range address error
//   mem_rw        1 = read, 0 = write on next clk edge
//   mem_addr      memory word address
//   mem_wdata     memory write data
//   mem_rdata     combinational memory read data
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [1:0]     req_we,
    input  logic [2*N-1:0] req_addr,
    input  logic [2*N-1:0] req_wdata,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [N-1:0]   rsp_rdata,
    output logic           rsp_err,
    output logic           mem_rw,
    output logic [N-1:0]   mem_addr,
    output logic [N-1:0]   mem_wdata,
    input  logic [N-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t       r_state;
    logic         r_we;
    logic         r_owner;
    logic         r_err;
    logic [N-1:0] r_addr;
    logic [N-1:0] r_wdata;
    logic [N-1:0] r_rdata;
`ifdef DMEM_ARB_RR_EN
    logic         r_last;
`endif

    logic [1:0]   w_grant;
    logic         w_sel;
    logic         w_in_range;
    logic         w_access;

    // Winner selection; a lone requester always wins
    always_comb begin
        w_grant = req_valid;
        if (req_valid == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            w_grant = r_last ? 2'b01 : 2'b10;
`else
            w_grant = 2'b01;
`endif
        end
    end

    assign w_sel      = w_grant[1];
    // Full-width unsigned compare: large addresses must not alias into range
    assign w_in_range = (r_addr < N'(DEPTH));

    // Transaction FSM and captured request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_owner <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
`ifdef DMEM_ARB_RR_EN
            r_last  <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_we    <= req_we[w_sel];
                        r_addr  <= w_sel ? req_addr[2*N-1:N]  : req_addr[N-1:0];
                        r_wdata <= w_sel ? req_wdata[2*N-1:N] : req_wdata[N-1:0];
                        r_owner <= w_sel;
`ifdef DMEM_ARB_RR_EN
                        r_last  <= w_sel;
`endif
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rdata <= (!r_we && w_in_range) ? mem_rdata : '0;
                    r_err   <= !w_in_range;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are gated by rst_n so a reset cycle never writes memory or
    // presents a response, even before the state register has been cleared
    assign w_access  = rst_n && (r_state == S_ACCESS);

    assign req_ready = (rst_n && (r_state == S_IDLE)) ? w_grant : 2'b00;
    assign rsp_valid = (rst_n && (r_state == S_RESP)) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = rst_n ? r_rdata : '0;
    assign rsp_err   = rst_n & r_err;

    assign mem_rw    = !(w_access && r_we && w_in_range);
    assign mem_addr  = w_access ? r_addr  : '0;
    assign mem_wdata = w_access ? r_wdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural 64-word memory.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 64;

    logic           clk;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [1:0]     req_we;
    logic [2*N-1:0] req_addr;
    logic [2*N-1:0] req_wdata;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [N-1:0]   rsp_rdata;
    logic           rsp_err;
    logic           mem_rw;
    logic [N-1:0]   mem_addr;
    logic [N-1:0]   mem_wdata;
    logic [N-1:0]   mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] mem [DEPTH];

    dmem_arbiter #(.N(N), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: synchronous write, combinational read
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (!mem_rw && (mem_addr < N'(DEPTH))) mem[mem_addr[5:0]] <= mem_wdata;
    end

    always_comb begin
        mem_rdata = '0;
        if (mem_addr < N'(DEPTH)) mem_rdata = mem[mem_addr[5:0]];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One complete uncontended transaction; starts just after a rising edge
    // with the DUT in IDLE and rsp_ready high for the owner
    task automatic txn(input int who, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input string tag);
        logic [1:0] oh;
        logic       exp_rw;
        oh     = (who == 1) ? 2'b10 : 2'b01;
        exp_rw = !(we && (addr < 32'(DEPTH)));
        req_we[who]              = we;
        req_addr[who*32 +: 32]   = addr;
        req_wdata[who*32 +: 32]  = wdata;
        req_valid                = oh;
        @(negedge clk);
        chk({tag, ".ready"},     32'(req_ready), 32'(oh));
        chk({tag, ".idle_rw"},   32'(mem_rw), 32'd1);
        chk({tag, ".idle_addr"}, mem_addr, 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk({tag, ".acc_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".acc_rw"},    32'(mem_rw), 32'(exp_rw));
        chk({tag, ".acc_addr"},  mem_addr, addr);
        chk({tag, ".acc_wdata"}, mem_wdata, wdata);
        chk({tag, ".acc_rsp"},   32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(oh));
        chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".rsp_err"},   32'(rsp_err), 32'(exp_err));
        chk({tag, ".rsp_rw"},    32'(mem_rw), 32'd1);
        chk({tag, ".rsp_ready"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    logic [1:0] exp_arb [4];

    initial begin
`ifdef DMEM_ARB_RR_EN
        exp_arb = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_arb = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_we    = 2'b11;
        req_addr  = {32'd1, 32'd2};
        req_wdata = {32'hA5A5_A5A5, 32'h5A5A_5A5A};
        rsp_ready = 2'b11;

        // Reset: requests present must be ignored, memory port idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.rsp_err",   32'(rsp_err), 32'd0);
        chk("rst.mem_rw",    32'(mem_rw), 32'd1);
        chk("rst.mem_addr",  mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        @(negedge clk);
        chk("post_rst.ready", 32'(req_ready), 32'd0);
        chk("post_rst.rsp",   32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        // Write then read back across requesters
        txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, "wr5");
        txn(1, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, "rd5");

        // Continuous contention, reads only
        req_we    = 2'b00;
        req_addr  = {32'd5, 32'd0};
        req_wdata = '0;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("arb%0d.grant", k), 32'(req_ready), 32'(exp_arb[k]));
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("arb%0d.rsp", k), 32'(rsp_valid), 32'(exp_arb[k]));
            chk($sformatf("arb%0d.rdata", k), rsp_rdata,
                (exp_arb[k] == 2'b10) ? 32'hDEAD_BEEF : 32'd0);
            @(posedge clk);
        end
        #1;
        req_valid = 2'b00;
        @(posedge clk); #1;

        // Out-of-range write: no memory write, error response
        txn(0, 1'b1, 32'd64, 32'h1, 32'd0, 1'b1, "wr64");
        txn(0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, "rd0");
        txn(1, 1'b0, 32'h8000_0005, 32'd0, 32'd0, 1'b1, "rd_big");

        // Response stall with the other requester waiting
        rsp_ready = 2'b10;
        req_we    = 2'b00;
        req_addr  = {32'd0, 32'd5};
        req_valid = 2'b01;
        @(negedge clk);
        chk("stall.ready0", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b10;
        @(negedge clk);
        chk("stall.acc_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d.rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d.rsp_rdata", k), rsp_rdata, 32'hDEAD_BEEF);
            chk($sformatf("stall%0d.req_ready", k), 32'(req_ready), 32'd0);
            @(posedge clk);
        end
        #1;
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("stall.rel_valid", 32'(rsp_valid), 32'd1);
        chk("stall.rel_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("stall.next_grant", 32'(req_ready), 32'd2);
        chk("stall.next_rsp",   32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("stall.r1_acc_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("stall.r1_rsp",   32'(rsp_valid), 32'd2);
        chk("stall.r1_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;

        // Reset during ACCESS of a write: transaction dropped
        req_we    = 2'b01;
        req_addr  = {32'd0, 32'd3};
        req_wdata = {32'd0, 32'h55};
        req_valid = 2'b01;
        @(negedge clk);
        chk("rstacc.ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("rstacc.mem_rw",   32'(mem_rw), 32'd1);
        chk("rstacc.mem_addr", mem_addr, 32'd0);
        chk("rstacc.rsp",      32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstacc.norsp%0d", k), 32'(rsp_valid), 32'd0);
            @(posedge clk);
        end
        #1;
        req_we = 2'b00;
        txn(0, 1'b0, 32'd3, 32'd0, 32'd0, 1'b0, "rd3");
        txn(1, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, "rd5b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
